// File: rtl/mpx_ch_regs.sv
// rtl/mpx_ch_regs.sv - multi-channel MPX register bank with coefficient FIFO and ROM loader
module mpx_ch_regs #(
    parameter int NCH        = 2,
    parameter int COEF_DEPTH = 16,
    parameter int ROM_AW     = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [NCH*32-1:0]   pilot_gain,
    output logic [NCH*32-1:0]   step,
    output logic [NCH*2-1:0]    stat_cfg,
    output logic [NCH*32-1:0]   stat_limit,
    input  logic [NCH*8-1:0]    stat_min,
    input  logic [NCH*8-1:0]    stat_max,
    input  logic [NCH*32-1:0]   stat_count,
    output logic [7:0]          rom_data,
    output logic [ROM_AW-1:0]   rom_addr,
    output logic [NCH-1:0]      rom_wr_en,
    output logic [24:0]         filter_cfg_tdata,
    output logic [NCH-1:0]      filter_cfg_tvalid,
    input  logic [NCH-1:0]      filter_cfg_tready
);

    localparam int AW = $clog2(COEF_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [4:0] NCH5 = 5'(NCH);

    // Per-channel state is sized for the full 4-bit bank space so bank can index it directly.
    logic [31:0]       pg_r     [16];
    logic [31:0]       step_r   [16];
    logic [1:0]        cfg_r    [16];
    logic [31:0]       limit_r  [16];
    logic [7:0]        shd_max  [16];
    logic [31:0]       shd_cnt  [16];
    logic [ROM_AW-1:0] rom_ptr  [16];
    logic [7:0]        min_a    [16];
    logic [7:0]        max_a    [16];
    logic [31:0]       cnt_a    [16];

    logic [28:0]       fifo_mem [COEF_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              overflow;

    logic [3:0]  bank;
    logic [5:0]  off;
    logic        access, bank_ch, bank_gl, wr, rd;
    logic        coef_wr, full, empty, push, pop;
    logic [3:0]  head_tag;
    logic [15:0] tready_w;
    logic        unused_ok;

    assign bank     = paddr[11:8];
    assign off      = paddr[7:2];
    assign access   = psel && penable;
    assign bank_ch  = ({1'b0, bank} < NCH5);
    assign bank_gl  = (bank == 4'hF);
    assign wr       = access && pwrite;
    assign rd       = access && !pwrite;
    assign coef_wr  = wr && bank_ch && (off == 6'h08);
    assign full     = (level == LW'(COEF_DEPTH));
    assign empty    = (level == '0);
    assign push     = coef_wr && !full;
    assign head_tag = fifo_mem[rd_ptr][28:25];
    assign tready_w = 16'(filter_cfg_tready);
    assign pop      = !empty && tready_w[head_tag];

    assign pready            = 1'b1;
    assign pslverr           = access && ((!bank_ch && !bank_gl) || (coef_wr && full));
    assign filter_cfg_tdata  = fifo_mem[rd_ptr][24:0];
    assign filter_cfg_tvalid = empty ? '0 : NCH'(16'b1 << head_tag);
    assign unused_ok         = &{1'b0, paddr[31:12], paddr[1:0]};

    genvar gc;
    generate
        for (gc = 0; gc < 16; gc++) begin : g_ch
            if (gc < NCH) begin : g_live
                assign pilot_gain[32*gc +: 32] = pg_r[gc];
                assign step[32*gc +: 32]       = step_r[gc];
                assign stat_cfg[2*gc +: 2]     = cfg_r[gc];
                assign stat_limit[32*gc +: 32] = limit_r[gc];
                assign min_a[gc]               = stat_min[8*gc +: 8];
                assign max_a[gc]               = stat_max[8*gc +: 8];
                assign cnt_a[gc]               = stat_count[32*gc +: 32];
            end else begin : g_tie
                assign min_a[gc] = '0;
                assign max_a[gc] = '0;
                assign cnt_a[gc] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 16; c++) begin
                pg_r[c]    <= 32'h256;
                step_r[c]  <= '0;
                cfg_r[c]   <= 2'b01;
                limit_r[c] <= '0;
                shd_max[c] <= '0;
                shd_cnt[c] <= '0;
                rom_ptr[c] <= '0;
            end
            rom_wr_en <= '0;
            rom_data  <= '0;
            rom_addr  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
        end else begin
            rom_wr_en <= '0;
            if (wr && bank_ch) begin
                case (off)
                    6'h00: pg_r[bank]    <= pwdata;
                    6'h01: begin
                        rom_wr_en     <= NCH'(16'b1 << bank);
                        rom_data      <= pwdata[7:0];
                        rom_addr      <= rom_ptr[bank];
                        rom_ptr[bank] <= rom_ptr[bank] + 1'b1;
                    end
                    6'h02: step_r[bank]  <= pwdata;
                    6'h03: cfg_r[bank]   <= pwdata[1:0];
                    6'h06: limit_r[bank] <= pwdata;
                    6'h09: rom_ptr[bank] <= pwdata[ROM_AW-1:0];
                    default: ;
                endcase
            end
            // Reading MIN freezes MAX/COUNT so the three reads describe one instant.
            if (rd && bank_ch && off == 6'h04) begin
                shd_max[bank] <= max_a[bank];
                shd_cnt[bank] <= cnt_a[bank];
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (coef_wr && full)
                overflow <= 1'b1;
            else if (wr && bank_gl && off == 6'h01 && pwdata[16])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bank, pwdata[24:0]};
    end

    always_comb begin
        prdata = '0;
        if (bank_ch) begin
            case (off)
                6'h00:   prdata = pg_r[bank];
                6'h02:   prdata = step_r[bank];
                6'h03:   prdata = 32'(cfg_r[bank]);
                6'h04:   prdata = 32'(min_a[bank]);
                6'h05:   prdata = 32'(shd_max[bank]);
                6'h06:   prdata = limit_r[bank];
                6'h07:   prdata = shd_cnt[bank];
                6'h09:   prdata = 32'(rom_ptr[bank]);
                default: prdata = '0;
            endcase
        end else if (bank_gl) begin
            case (off)
                6'h00:   prdata = {16'h4D50, 8'(NCH), 8'h02};
                6'h01:   prdata = {15'b0, overflow, 8'b0, 8'(level)};
                default: prdata = '0;
            endcase
        end
    end

endmodule

// File: doc/mpx_ch_regs.md
# mpx_ch_regs

Multi-channel APB register block for the MPX path; it replaces the single-channel register file. It holds one register bank per MPX channel, buffers filter-coefficient writes in a shared FIFO with per-channel valid/ready delivery, and auto-increments the ROM load address. Statistics reads are snapshot-coherent. It sits between the APB interconnect and the NCH MPX channel datapaths.

## Interface
- NCH, 2, number of channels (1..15)
- COEF_DEPTH, 16, coefficient FIFO depth (power of two, 2..128)
- ROM_AW, 10, ROM address width
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- penable, psel, pwrite  in  1  APB control
- paddr  in  32  byte address; only [11:2] decoded
- pwdata  in  32  write data
- prdata  out  32  read data, combinational
- pready  out  1  tied 1
- pslverr  out  1  error, valid in the access phase
- pilot_gain  out  NCH*32  per-channel pilot gain; channel c occupies [32c+31:32c]
- step  out  NCH*32  per-channel NCO step
- stat_cfg  out  NCH*2  per-channel stat config
- stat_limit  out  NCH*32  per-channel stat window
- stat_min, stat_max  in  NCH*8  live statistics
- stat_count  in  NCH*32  live count
- rom_data  out  8  ROM write data, shared
- rom_addr  out  ROM_AW  ROM write address, shared
- rom_wr_en  out  NCH  one-cycle write pulse per channel
- filter_cfg_tdata  out  25  coefficient at FIFO head
- filter_cfg_tvalid  out  NCH  head valid, one-hot by head channel tag
- filter_cfg_tready  in  NCH  per-channel accept

## Operation
- Access: an access occurs when psel && penable. Bank b = paddr[11:8]. Offset o = {paddr[7:2],2'b00}.
- Channel bank (b < NCH):
  - 0x00 PILOT_GAIN RW
  - 0x04 ROM_DATA WO
  - 0x08 STEP RW
  - 0x0C STAT_CFG RW [1:0]
  - 0x10 STAT_MIN RO
  - 0x14 STAT_MAX RO
  - 0x18 STAT_LIMIT RW
  - 0x1C STAT_COUNT RO
  - 0x20 COEF WO [24:0]
  - 0x24 ROM_ADDR RW [ROM_AW-1:0]
- Global bank (b = 0xF):
  - 0x00 ID RO = {16'h4D50, 8'(NCH), 8'h02}
  - 0x04 COEF_STATUS: [7:0] FIFO level RO; [16] overflow sticky, write 1 to clear
- Unmapped offsets: read 0, writes ignored, no error.
- pslverr = 1 for either of:
  - any access to a bank that is neither < NCH nor 0xF
  - a COEF write while the FIFO is full; the write is dropped and overflow is set
- Reset values (all channels):
  - pilot_gain 'h256, step 0, stat_cfg 1, stat_limit 0
  - ROM pointers 0, rom_wr_en 0, rom_data 0, rom_addr 0
  - FIFO empty, tvalid 0, overflow 0, snapshot shadows 0
- Snapshot: a read of STAT_MIN(c) returns live stat_min[c]. In the same cycle it latches stat_max[c] and stat_count[c] into channel-c shadows. Reads of STAT_MAX and STAT_COUNT return the shadows.
- ROM: a ROM_DATA write to channel c produces, on the next cycle:
  - rom_wr_en[c] = 1 for one cycle
  - rom_data = pwdata[7:0]
  - rom_addr = ptr[c]
  - ptr[c] increments, wrapping from 2^ROM_AW-1 to 0
- A ROM_ADDR write loads ptr[c]. A read returns ptr[c].
- Coefficient FIFO:
  - Entries are {channel tag, 25-bit data}.
  - Push: a COEF write when the FIFO is not full.
  - Head: filter_cfg_tvalid[tag] = 1 when non-empty; tdata = head data.
  - Pop: when tvalid[tag] && tready[tag].
  - Entries are delivered strictly in order; a stalled head blocks every channel.
  - Full is evaluated on the registered level. A push while full fails even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves level unchanged.
- A COEF_STATUS write with bit16 = 1 clears overflow. If overflow is set in that same cycle, set wins.

## Timing
- Zero wait states; pready is always 1.
- prdata and pslverr are combinational from paddr and state.
- RW register outputs update on the clk edge that ends the access phase, visible the next cycle.
- The rom_wr_en pulse follows the access edge by one cycle.
- FIFO: write at edge k gives tvalid high at k+1 (if previously empty); level updates at k.
- Asserting reset_n low clears all state immediately, mid-transfer included; in-flight FIFO contents are lost.

## Test plan
- Reset then read ch0 0x00 and 0xF00 with NCH=2 -> 0x256 and 0x4D500202; every output equals its reset value.
- Write STEP ch1 = 0xDEADBEEF, read back -> step[63:32] = 0xDEADBEEF, step[31:0] unchanged at 0; access to bank 2 -> pslverr=1.
- Write ROM_ADDR ch0 = 0x3FE, then three ROM_DATA writes 0x11/0x22/0x33 -> pulses at addresses 0x3FE, 0x3FF, 0x000; ROM_ADDR readback = 0x001.
- Hold tready=0 and write 17 COEFs (depth 16) -> 17th gets pslverr=1; COEF_STATUS = 0x10010; W1C clears bit16.
- Interleave COEF writes ch0 0x1, ch1 0x2, ch0 0x3 with tready[1] held low -> 0x1 delivered, then 0x3 blocked until tready[1] rises; order 1,2,3.
- Change stat inputs between the STAT_MIN read and the STAT_MAX/STAT_COUNT reads -> returned max/count equal the values present at the MIN read.
